// File: rtl/activation_stream.sv
// activation_stream: credit-controlled stream wrapper around a per-lane activation unit
// (identity / GELU / ReLU) with a first-word fall-through output buffer.
// Optional statistics counters (beats_o, stall_o) are built when ACTIVATION_STREAM_STATS_EN is defined.
module activation_stream #(
    parameter int N_PE       = 16,
    parameter int LATENCY    = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int DATA_W     = 8,
    parameter int COEF_W     = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        cfg_valid_i,
    input  logic [2:0]                  cfg_addr_i,
    input  logic [COEF_W-1:0]           cfg_data_i,
    output logic                        cfg_ready_o,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    input  logic [N_PE-1:0][DATA_W-1:0] in_data_i,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic [N_PE-1:0][DATA_W-1:0] out_data_o,
    input  logic                        flush_i,
    output logic                        busy_o
`ifdef ACTIVATION_STREAM_STATS_EN
    ,
    output logic [31:0]                 beats_o,
    output logic [31:0]                 stall_o
`endif
);

    typedef enum logic [1:0] {ACT_IDENTITY = 2'd0, ACT_GELU = 2'd1, ACT_RELU = 2'd2} activation_e;
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FLUSH = 2'd2} state_e;

    localparam int WIDE  = 64;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
    localparam logic signed [WIDE-1:0] SAT_MAX = (64'sd1 <<< (DATA_W - 1)) - 64'sd1;
    localparam logic signed [WIDE-1:0] SAT_MIN = -(64'sd1 <<< (DATA_W - 1));

    function automatic logic [DATA_W-1:0] saturate(input logic signed [WIDE-1:0] v);
        logic [DATA_W-1:0] r;
        if (v > SAT_MAX)      r = SAT_MAX[DATA_W-1:0];
        else if (v < SAT_MIN) r = SAT_MIN[DATA_W-1:0];
        else                  r = v[DATA_W-1:0];
        return r;
    endfunction

    // Polynomial erf approximation: x * (sgn(x)*((min(|x|,-b)+b)^2 + c) + one), then requantise.
    // All intermediates fit in 64 bits for 8-bit lanes and 16-bit constants.
    function automatic logic [DATA_W-1:0] gelu(
        input logic signed [DATA_W-1:0] x,
        input logic signed [COEF_W-1:0] one,
        input logic signed [COEF_W-1:0] b,
        input logic signed [COEF_W-1:0] c,
        input logic signed [COEF_W-1:0] eps_mult,
        input logic signed [COEF_W-1:0] add,
        input logic        [COEF_W-1:0] right_shift
    );
        logic signed [WIDE-1:0] xw, ax, nb, q, d, erf, y;
        xw  = WIDE'(x);
        ax  = (xw < 0) ? -xw : xw;
        nb  = -WIDE'(b);
        q   = (ax < nb) ? ax : nb;
        d   = q - nb;
        erf = d * d + WIDE'(c);
        if (xw < 0) erf = -erf;
        y   = (xw * (erf + WIDE'(one)) * WIDE'(eps_mult)) >>> right_shift;
        return saturate(y + WIDE'(add));
    endfunction

    function automatic logic [DATA_W-1:0] relu(input logic signed [DATA_W-1:0] x);
        return x[DATA_W-1] ? '0 : x;
    endfunction

    logic signed [COEF_W-1:0] one_q, b_q, c_q, eps_mult_q, add_q;
    logic        [COEF_W-1:0] right_shift_q;
    activation_e              act_q;

    state_e                      state_q, state_nxt;
    logic [CNT_W-1:0]            occ_q, occ_nxt;
    logic [LATENCY-1:0]          vld_p;
    logic [N_PE-1:0][DATA_W-1:0] dat_p [LATENCY];
    logic [N_PE-1:0][DATA_W-1:0] act_dat;
    logic [N_PE-1:0][DATA_W-1:0] mem [FIFO_DEPTH];
    logic [N_PE-1:0][DATA_W-1:0] head;
    logic [PTR_W-1:0]            wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]            fifo_cnt_q;
    logic                        fifo_empty, fifo_wr, fifo_rd;
    logic                        in_hs, out_hs, cfg_hs;

    assign cfg_ready_o = (state_q == S_IDLE);
    assign cfg_hs      = cfg_valid_i && cfg_ready_o;
    assign in_ready_o  = !rst_i && (occ_q < DEPTH_C) && (state_q != S_FLUSH) && !flush_i;
    assign in_hs       = in_valid_i && in_ready_o;
    assign busy_o      = (occ_q != '0);

    // The buffer is bypassed when empty so the pipeline tail reaches the output directly.
    assign fifo_empty  = (fifo_cnt_q == '0);
    assign head        = fifo_empty ? dat_p[LATENCY-1] : mem[rd_ptr_q];
    assign out_valid_o = !fifo_empty || vld_p[LATENCY-1];
    assign out_data_o  = out_valid_o ? head : '0;
    assign out_hs      = out_valid_o && out_ready_i;
    assign fifo_wr     = vld_p[LATENCY-1] && !(fifo_empty && out_ready_i);
    assign fifo_rd     = out_hs && !fifo_empty;
    assign occ_nxt     = occ_q + CNT_W'(in_hs) - CNT_W'(out_hs);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            one_q         <= '0;
            b_q           <= '0;
            c_q           <= '0;
            eps_mult_q    <= '0;
            right_shift_q <= '0;
            add_q         <= '0;
            act_q         <= ACT_IDENTITY;
        end else if (cfg_hs) begin
            case (cfg_addr_i)
                3'd0: one_q         <= cfg_data_i;
                3'd1: b_q           <= cfg_data_i;
                3'd2: c_q           <= cfg_data_i;
                3'd3: eps_mult_q    <= cfg_data_i;
                3'd4: right_shift_q <= cfg_data_i;
                3'd5: add_q         <= cfg_data_i;
                3'd6: act_q         <= activation_e'(cfg_data_i[1:0]);
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            S_IDLE:  if (in_hs) state_nxt = S_RUN;
            S_RUN:   if (occ_nxt == '0) state_nxt = S_IDLE;
            S_FLUSH: if (occ_nxt == '0) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (flush_i) state_nxt = S_FLUSH;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            occ_q   <= '0;
        end else begin
            state_q <= state_nxt;
            occ_q   <= occ_nxt;
        end
    end

    // Stage p0: activation evaluated on the incoming beat with the registered constants
    always_comb begin
        act_dat = in_data_i;
        for (int l = 0; l < N_PE; l++) begin
            case (act_q)
                ACT_GELU: act_dat[l] = gelu(in_data_i[l], one_q, b_q, c_q, eps_mult_q, add_q, right_shift_q);
                ACT_RELU: act_dat[l] = relu(in_data_i[l]);
                default:  act_dat[l] = in_data_i[l];
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_p <= '0;
        end else begin
            vld_p[0] <= in_hs;
            for (int i = 1; i < LATENCY; i++) vld_p[i] <= vld_p[i-1];
        end
    end

    always_ff @(posedge clk_i) begin
        dat_p[0] <= act_dat;
        for (int i = 1; i < LATENCY; i++) dat_p[i] <= dat_p[i-1];
    end

    // Output buffer: pipeline tail -> FIFO
    always_ff @(posedge clk_i) begin
        if (fifo_wr) mem[wr_ptr_q] <= dat_p[LATENCY-1];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (fifo_wr) wr_ptr_q <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
            if (fifo_rd) rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
            fifo_cnt_q <= fifo_cnt_q + CNT_W'(fifo_wr) - CNT_W'(fifo_rd);
        end
    end

`ifdef ACTIVATION_STREAM_STATS_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            beats_o <= '0;
            stall_o <= '0;
        end else begin
            if (out_hs && (beats_o != '1)) beats_o <= beats_o + 32'd1;
            if (out_valid_o && !out_ready_i && (stall_o != '1)) stall_o <= stall_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_activation_stream.sv
// Bench for activation_stream: directed and random beats, expected beats queued from an
// integer reference model and compared by an independent output monitor.
`timescale 1ns/1ps
module tb_activation_stream;

    localparam int N_PE       = 16;
    localparam int LATENCY    = 2;
    localparam int FIFO_DEPTH = 5;
    localparam int DATA_W     = 8;
    localparam int COEF_W     = 16;

    typedef logic [N_PE-1:0][DATA_W-1:0] beat_t;
    typedef struct {
        beat_t  data;
        longint acc;
        bit     chk_lat;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              cfg_valid;
    logic [2:0]        cfg_addr;
    logic [COEF_W-1:0] cfg_data;
    logic              cfg_ready;
    logic              in_valid;
    logic              in_ready;
    beat_t             in_data;
    logic              out_valid;
    logic              out_ready;
    beat_t             out_data;
    logic              flush;
    logic              busy;
`ifdef ACTIVATION_STREAM_STATS_EN
    logic [31:0]       beats;
    logic [31:0]       stall;
`endif

    activation_stream #(
        .N_PE(N_PE), .LATENCY(LATENCY), .FIFO_DEPTH(FIFO_DEPTH), .DATA_W(DATA_W), .COEF_W(COEF_W)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .cfg_valid_i(cfg_valid), .cfg_addr_i(cfg_addr), .cfg_data_i(cfg_data), .cfg_ready_o(cfg_ready),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
        .flush_i(flush), .busy_o(busy)
`ifdef ACTIVATION_STREAM_STATS_EN
        , .beats_o(beats), .stall_o(stall)
`endif
    );

    always #5 clk = ~clk;

    int     total = 0;
    int     bad   = 0;
    int     n_out = 0;
    longint cyc   = 0;
    exp_t   exp_q[$];

    longint m_one, m_b, m_c, m_eps, m_shift, m_add;
    int     m_sel;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic check_beat(input string name, input beat_t act, input beat_t req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Reference: 0 identity (also unknown selects), 1 GELU polynomial, 2 ReLU.
    function automatic int ref_lane(input int x);
        longint ax, lim, d, poly, y;
        case (m_sel)
            2: return (x < 0) ? 0 : x;
            1: begin
                ax   = (x < 0) ? -x : x;
                lim  = -m_b;
                d    = ((ax < lim) ? ax : lim) + m_b;
                poly = d * d + m_c;
                if (x < 0) poly = -poly;
                y = (longint'(x) * (poly + m_one) * m_eps) >>> m_shift;
                y = y + m_add;
                if (y > 127) y = 127;
                if (y < -128) y = -128;
                return int'(y);
            end
            default: return x;
        endcase
    endfunction

    function automatic beat_t ref_beat(input beat_t d);
        beat_t r;
        logic signed [DATA_W-1:0] x;
        for (int l = 0; l < N_PE; l++) begin
            x    = d[l];
            r[l] = DATA_W'(ref_lane(int'(x)));
        end
        return r;
    endfunction

    function automatic beat_t rand_beat();
        beat_t r;
        for (int l = 0; l < N_PE; l++) r[l] = DATA_W'($urandom);
        return r;
    endfunction

    task automatic push_exp(input beat_t e, input bit chk);
        exp_t x;
        x.data = e;
        x.acc = cyc;
        x.chk_lat = chk;
        exp_q.push_back(x);
    endtask

    task automatic send_beat(input beat_t d, input beat_t e, input bit chk);
        int waited = 0;
        in_valid = 1'b1;
        in_data  = d;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
            if (waited > 200) break;
        end
        if (in_ready) push_exp(e, chk);
        else check_val("send_timeout", 64'(in_ready), 64'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic cfg_write(input int addr, input int data);
        int waited = 0;
        logic [15:0]        u;
        logic signed [15:0] s;
        cfg_valid = 1'b1;
        cfg_addr  = 3'(addr);
        cfg_data  = 16'(data);
        forever begin
            @(negedge clk);
            if (cfg_ready) break;
            waited++;
            if (waited > 200) break;
        end
        if (!cfg_ready) check_val("cfg_timeout", 64'(cfg_ready), 64'(1));
        u = 16'(data);
        s = u;
        case (addr)
            0: m_one   = s;
            1: m_b     = s;
            2: m_c     = s;
            3: m_eps   = s;
            4: m_shift = u;
            5: m_add   = s;
            6: m_sel   = int'(u[1:0]);
            default: ;
        endcase
        @(posedge clk); #1;
        cfg_valid = 1'b0;
    endtask

    task automatic run_cycles(input int n, input int in_pct, input int out_pct, input bit chk);
        beat_t d;
        for (int i = 0; i < n; i++) begin
            d         = rand_beat();
            in_data   = d;
            in_valid  = (int'($urandom_range(99)) < in_pct);
            out_ready = (int'($urandom_range(99)) < out_pct);
            @(negedge clk);
            if (in_valid && in_ready) push_exp(ref_beat(d), chk);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(input int limit);
        int n = 0;
        out_ready = 1'b1;
        while ((exp_q.size() != 0 || busy) && n < limit) begin
            @(negedge clk);
            n++;
        end
        check_val("drain_left", 64'(exp_q.size()), 64'(0));
        @(posedge clk); #1;
    endtask

    task automatic gelu_setup(input int shift_lo, input int shift_hi);
        cfg_write(0, int'($urandom_range(1000)) - 500);
        cfg_write(1, -int'($urandom_range(100, 1)));
        cfg_write(2, int'($urandom_range(4000)) - 2000);
        cfg_write(3, int'($urandom_range(200, 1)));
        cfg_write(4, int'($urandom_range(shift_hi, shift_lo)));
        cfg_write(5, int'($urandom_range(100)) - 50);
        cfg_write(6, 1);
    endtask

    // Output monitor: head must match the oldest expected beat whenever valid.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                if (out_ready) check_val("spurious_out", 64'(out_valid), 64'(0));
            end else begin
                check_beat("out_data", out_data, exp_q[0].data);
                if (out_ready) begin
                    if (exp_q[0].chk_lat) check_val("latency", 64'(cyc - exp_q[0].acc), 64'(LATENCY));
                    void'(exp_q.pop_front());
                    n_out++;
                end
            end
        end
    end

    initial begin
        int    accepted;
        int    base;
        int    n;
        beat_t d, e;
        int    rin [5] = '{-128, -1, 0, 5, 127};
        int    rout[5] = '{0, 0, 0, 5, 127};

        rst = 1'b1; cfg_valid = 1'b0; cfg_addr = '0; cfg_data = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;
        m_one = 0; m_b = 0; m_c = 0; m_eps = 0; m_shift = 0; m_add = 0; m_sel = 0;

        #12;
        check_val("rst_in_ready", 64'(in_ready), 64'(0));
        check_val("rst_out_valid", 64'(out_valid), 64'(0));
        check_val("rst_busy", 64'(busy), 64'(0));
        check_beat("rst_out_data", out_data, '0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_val("rel_in_ready", 64'(in_ready), 64'(1));
        check_val("rel_cfg_ready", 64'(cfg_ready), 64'(1));
        @(posedge clk); #1;

        // identity, free flowing, latency checked
        out_ready = 1'b1;
        run_cycles(8, 100, 100, 1);
        drain(50);

        // ReLU with boundary lane values and hand-computed results
        cfg_write(6, 2);
        for (int l = 0; l < N_PE; l++) begin
            d[l] = DATA_W'(rin[l % 5]);
            e[l] = DATA_W'(rout[l % 5]);
        end
        out_ready = 1'b1;
        send_beat(d, e, 1'b1);
        run_cycles(6, 100, 100, 1);
        drain(50);

        // GELU with random constants, random handshakes
        gelu_setup(8, 20);
        run_cycles(150, 70, 60, 0);
        drain(100);
        gelu_setup(0, 4);
        cfg_write(7, 1234);
        run_cycles(100, 80, 50, 0);
        drain(100);

        // output stalled, continuous input: exactly FIFO_DEPTH accepted
        out_ready = 1'b0;
        accepted  = 0;
        for (int i = 0; i < FIFO_DEPTH + 6; i++) begin
            d        = rand_beat();
            in_data  = d;
            in_valid = 1'b1;
            @(negedge clk);
            if (in_ready) begin
                push_exp(ref_beat(d), 1'b0);
                accepted++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check_val("bp_accepted", 64'(accepted), 64'(FIFO_DEPTH));
        @(negedge clk);
        check_val("bp_in_ready", 64'(in_ready), 64'(0));
        check_val("bp_busy", 64'(busy), 64'(1));
        @(posedge clk); #1;
        drain(100);

        // cfg write while beats in flight stalls until idle
        cfg_write(6, 0);
        out_ready = 1'b0;
        d = rand_beat();
        send_beat(d, ref_beat(d), 1'b0);
        cfg_valid = 1'b1; cfg_addr = 3'd6; cfg_data = 16'd2;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("run_cfg_ready", 64'(cfg_ready), 64'(0));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        cfg_write(6, 2);
        @(negedge clk);
        check_val("cfg_after_busy", 64'(busy), 64'(0));
        check_val("cfg_after_q", 64'(exp_q.size()), 64'(0));
        @(posedge clk); #1;
        run_cycles(6, 100, 100, 1);
        drain(50);

        // flush with 3 beats buffered
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            d = rand_beat();
            send_beat(d, ref_beat(d), 1'b0);
        end
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = rand_beat();
        @(negedge clk);
        check_val("flush_in_ready", 64'(in_ready), 64'(0));
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check_val("flushing_in_ready", 64'(in_ready), 64'(0));
        check_val("flushing_busy", 64'(busy), 64'(1));
        in_valid  = 1'b0;
        base      = n_out;
        out_ready = 1'b1;
        n = 0;
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check_val("flush_out_count", 64'(n_out - base), 64'(3));
        check_val("flush_busy", 64'(busy), 64'(0));
        check_val("flush_cfg_ready", 64'(cfg_ready), 64'(1));
        check_val("flush_in_ready_after", 64'(in_ready), 64'(1));
        @(posedge clk); #1;

        // reset with the buffer partly full
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            d = rand_beat();
            send_beat(d, ref_beat(d), 1'b0);
        end
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check_val("midrst_out_valid", 64'(out_valid), 64'(0));
        check_val("midrst_busy", 64'(busy), 64'(0));
        check_val("midrst_in_ready", 64'(in_ready), 64'(0));
        exp_q.delete();
        m_one = 0; m_b = 0; m_c = 0; m_eps = 0; m_shift = 0; m_add = 0; m_sel = 0;
        @(posedge clk); #3;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("postrst_out_valid", 64'(out_valid), 64'(0));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        run_cycles(6, 100, 100, 1);
        drain(50);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/activation_stream.md
ACTIVATION_STREAM -- requirements
Module: activation_stream

Interface
REQ-001 SHALL have parameter N_PE, default 16, number of parallel lanes per beat.
REQ-002 SHALL have parameter LATENCY, default 1, register depth of the wrapped activation datapath, minimum 1.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, output buffer entries, minimum LATENCY+1.
REQ-004 SHALL have port clk_i  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports cfg_valid_i input 1, cfg_addr_i input 3, cfg_data_i input GELU_CONSTANTS_WIDTH, cfg_ready_o output 1: constant/mode register write.
REQ-007 SHALL have ports in_valid_i input 1, in_ready_o output 1, in_data_i input requant_oup_t: preactivation beat.
REQ-008 SHALL have ports out_valid_o output 1, out_ready_i input 1, out_data_o output requant_oup_t: postactivation beat.
REQ-009 SHALL have port flush_i input 1: stop intake and drain; busy_o output 1: any beat in flight or buffered.

Function
REQ-010 SHALL map cfg_addr_i 0..6 to one, b, c, eps_mult, right_shift, add, activation select (activation_e); addresses 7 ignored, no error.
REQ-011 SHALL accept a cfg write on cycle with cfg_valid_i && cfg_ready_o; cfg_ready_o SHALL be 1 only in state IDLE.
REQ-012 SHALL drive the wrapped activation unit only from the registered constants; constants SHALL NOT change while any beat is in flight.
REQ-013 SHALL implement states IDLE (occupancy 0), RUN (occupancy>0), FLUSH; IDLE->RUN on input handshake; RUN->IDLE when occupancy returns 0 with no handshake; any state->FLUSH on flush_i; FLUSH->IDLE when occupancy 0.
REQ-014 SHALL track occupancy = beats in datapath pipeline + beats in FIFO, range 0..FIFO_DEPTH.
REQ-015 SHALL assert in_ready_o iff occupancy < FIFO_DEPTH and state != FLUSH and flush_i low (credit scheme; FIFO never overflows).
REQ-016 SHALL deliver each accepted beat to the FIFO exactly LATENCY cycles after its input handshake via a LATENCY-deep valid shift register.
REQ-017 SHALL present FIFO head on out_data_o with out_valid_o=1 whenever FIFO non-empty; out_data_o SHALL hold stable while out_valid_o && !out_ready_i.
REQ-018 SHALL keep occupancy unchanged on simultaneous input and output handshake; +1 on input only; -1 on output only.
REQ-019 SHALL preserve beat order; no beat dropped or duplicated; FIFO read/write pointers wrap modulo FIFO_DEPTH.
REQ-020 SHALL assert busy_o iff occupancy > 0.
REQ-021 SHALL give minimum in-to-out latency LATENCY+0 cycles from accept to out_valid_o (FIFO first-word fall-through), full throughput 1 beat/cycle when out_ready_i held high.

Reset
REQ-022 SHALL on rst_i assert immediately clear: state IDLE, occupancy 0, FIFO pointers 0, valid shift register 0.
REQ-023 SHALL reset outputs: in_ready_o 0 during reset then 1, out_valid_o 0, out_data_o 0, cfg_ready_o 1 after release, busy_o 0.
REQ-024 SHALL reset constants to 0 and activation select to IDENTITY; reset mid-operation SHALL discard all in-flight beats.

Configuration
REQ-025 SHALL with macro ACTIVATION_STREAM_STATS_EN defined add outputs beats_o (32b, output handshakes) and stall_o (32b, cycles out_valid_o && !out_ready_i), saturating, reset 0.
REQ-026 SHALL without ACTIVATION_STREAM_STATS_EN omit those ports and counters entirely.

Verification
REQ-027 SHALL cover: select IDENTITY, 8 beats, out_ready_i=1 -> 8 outputs equal inputs, each LATENCY cycles after accept.
REQ-028 SHALL cover: select RELU, lane values -128,-1,0,5,127 -> outputs 0,0,0,5,127.
REQ-029 SHALL cover: GELU constants and vectors from GELU_*.txt / preactivation.txt -> outputs match postactivation.txt, 0 mismatches.
REQ-030 SHALL cover: out_ready_i=0, continuous in_valid_i -> exactly FIFO_DEPTH beats accepted, in_ready_o 0 thereafter, out_data_o stable; releasing ready drains in order.
REQ-031 SHALL cover: cfg write during RUN -> cfg_ready_o 0, write stalls until IDLE; flush_i with 3 beats in flight -> in_ready_o 0, 3 beats out, then IDLE, busy_o 0.
REQ-032 SHALL cover: rst_i asserted with FIFO half full -> out_valid_o 0 same cycle, no stale beat after release.
